// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: fetch-side and RAS-side signal bundle for ras_ctrl.
// Optional statistics signals are present when RAS_CTRL_STATS_EN is defined.
interface ras_ctrl_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic [31:0]     fetch_instr_i;
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] ras_top_i;
  logic            ras_empty_i;
  logic            ras_push_o;
  logic            ras_pop_o;
  logic [XLEN-1:0] ras_data_o;
  logic            pred_valid_o;
  logic [XLEN-1:0] pred_target_o;
  logic            busy_o;
`ifdef RAS_CTRL_STATS_EN
  logic [31:0]     stat_call_o;
  logic [31:0]     stat_ret_o;
  logic [15:0]     stat_underflow_o;

  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_instr_i, stall_i, flush_i,
    input  ras_top_i, ras_empty_i,
    output ras_push_o, ras_pop_o, ras_data_o,
    output pred_valid_o, pred_target_o, busy_o,
    output stat_call_o, stat_ret_o, stat_underflow_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_instr_i, stall_i, flush_i,
    output ras_top_i, ras_empty_i,
    input  ras_push_o, ras_pop_o, ras_data_o,
    input  pred_valid_o, pred_target_o, busy_o,
    input  stat_call_o, stat_ret_o, stat_underflow_o
  );
`else
  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_instr_i, stall_i, flush_i,
    input  ras_top_i, ras_empty_i,
    output ras_push_o, ras_pop_o, ras_data_o,
    output pred_valid_o, pred_target_o, busy_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_instr_i, stall_i, flush_i,
    output ras_top_i, ras_empty_i,
    input  ras_push_o, ras_pop_o, ras_data_o,
    input  pred_valid_o, pred_target_o, busy_o
  );
`endif
endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl: call/return detector and push/pop sequencer for the return
// address stack. Classifies RV32I JAL/JALR by link-register usage, emits
// registered one-cycle push/pop pulses and a same-cycle return prediction.
// Coroutine (pop-then-push) jumps are serialized over two cycles.
// Optional feature macro: RAS_CTRL_STATS_EN (saturating call/return/underflow counters).
module ras_ctrl #(
  parameter int XLEN = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  ras_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_COPOP   = 2'd2;
  localparam logic [1:0] ST_COPUSH  = 2'd3;

  localparam logic [1:0] CL_NONE    = 2'd0;
  localparam logic [1:0] CL_PUSH    = 2'd1;
  localparam logic [1:0] CL_POP     = 2'd2;
  localparam logic [1:0] CL_POPPUSH = 2'd3;

  // x1 (ra) and x5 (t0) are the RISC-V link registers
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [1:0] classify(input logic [31:0] instr);
    logic [1:0] cls;
    logic       rd_link;
    logic       rs_link;
    rd_link = is_link(instr[11:7]);
    rs_link = is_link(instr[19:15]);
    cls     = CL_NONE;
    if (instr[6:0] == 7'b1101111) begin
      if (rd_link) cls = CL_PUSH;
      else         cls = CL_NONE;
    end else if ((instr[6:0] == 7'b1100111) && (instr[14:12] == 3'b000)) begin
      if (rd_link && !rs_link)                              cls = CL_PUSH;
      else if (rd_link && rs_link && (instr[11:7] == instr[19:15])) cls = CL_PUSH;
      else if (rd_link && rs_link)                          cls = CL_POPPUSH;
      else if (rs_link)                                     cls = CL_POP;
      else                                                  cls = CL_NONE;
    end else begin
      cls = CL_NONE;
    end
    return cls;
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      nxt_state_s;
  logic            push_r;
  logic            pop_r;
  logic [XLEN-1:0] data_r;
  logic            nxt_push_s;
  logic            nxt_pop_s;
  logic [XLEN-1:0] nxt_data_s;
  logic [1:0]      cls_s;
  logic            accept_s;
  logic            ret_class_s;
  logic [XLEN-1:0] ret_addr_s;

  assign cls_s       = classify(bus.fetch_instr_i);
  assign accept_s    = (state_r == ST_IDLE) && bus.fetch_valid_i && !bus.stall_i && !bus.flush_i;
  assign ret_class_s = (cls_s == CL_POP) || (cls_s == CL_POPPUSH);
  assign ret_addr_s  = bus.fetch_pc_i + XLEN'(4);

  // Next state and next pulse values; pulses are registered so they land one cycle after the decision
  always_comb begin
    nxt_state_s = state_r;
    nxt_push_s  = 1'b0;
    nxt_pop_s   = 1'b0;
    nxt_data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cls_s)
            CL_PUSH: begin
              nxt_data_s  = ret_addr_s;
              nxt_push_s  = 1'b1;
              nxt_state_s = ST_ISSUE;
            end
            CL_POP: begin
              if (!bus.ras_empty_i) begin
                nxt_pop_s   = 1'b1;
                nxt_state_s = ST_ISSUE;
              end else begin
                nxt_state_s = ST_IDLE;
              end
            end
            CL_POPPUSH: begin
              nxt_data_s = ret_addr_s;
              if (!bus.ras_empty_i) begin
                nxt_pop_s   = 1'b1;
                nxt_state_s = ST_COPOP;
              end else begin
                nxt_push_s  = 1'b1;
                nxt_state_s = ST_ISSUE;
              end
            end
            default: nxt_state_s = ST_IDLE;
          endcase
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_ISSUE:  nxt_state_s = ST_IDLE;
      ST_COPOP: begin
        nxt_push_s  = 1'b1;
        nxt_state_s = ST_COPUSH;
      end
      ST_COPUSH: nxt_state_s = ST_IDLE;
      default:   nxt_state_s = ST_IDLE;
    endcase
  end

  // State, pulse and push-data registers; reset aborts any sequence in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      push_r  <= 1'b0;
      pop_r   <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= nxt_state_s;
      push_r  <= nxt_push_s;
      pop_r   <= nxt_pop_s;
      data_r  <= nxt_data_s;
    end
  end

  // Same-cycle return prediction, only while idle
  always_comb begin
    bus.pred_valid_o  = 1'b0;
    bus.pred_target_o = '0;
    if ((state_r == ST_IDLE) && ret_class_s && bus.fetch_valid_i &&
        !bus.ras_empty_i && !bus.flush_i) begin
      bus.pred_valid_o  = 1'b1;
      bus.pred_target_o = bus.ras_top_i;
    end else begin
      bus.pred_valid_o  = 1'b0;
      bus.pred_target_o = '0;
    end
  end

  assign bus.ras_push_o = push_r;
  assign bus.ras_pop_o  = pop_r;
  assign bus.ras_data_o = data_r;
  assign bus.busy_o     = (state_r != ST_IDLE);

`ifdef RAS_CTRL_STATS_EN
  logic [31:0] stat_call_r;
  logic [31:0] stat_ret_r;
  logic [15:0] stat_uf_r;
  logic        uf_event_s;

  assign uf_event_s = accept_s && ret_class_s && bus.ras_empty_i;

  // Saturating counters of issued pushes, issued pops and returns seen on an empty RAS
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_call_r <= 32'd0;
      stat_ret_r  <= 32'd0;
      stat_uf_r   <= 16'd0;
    end else begin
      if (nxt_push_s && (stat_call_r != 32'hFFFF_FFFF)) stat_call_r <= stat_call_r + 32'd1;
      if (nxt_pop_s && (stat_ret_r != 32'hFFFF_FFFF))   stat_ret_r  <= stat_ret_r + 32'd1;
      if (uf_event_s && (stat_uf_r != 16'hFFFF))        stat_uf_r   <= stat_uf_r + 16'd1;
    end
  end

  assign bus.stat_call_o      = stat_call_r;
  assign bus.stat_ret_o       = stat_ret_r;
  assign bus.stat_underflow_o = stat_uf_r;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl. The driver classifies each
// instruction with a rule-level model and queues the expected push/pop
// events; an independent monitor checks every pulse the DUT emits.
module tb_ras_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  ras_ctrl_if #(.XLEN(32)) bus ();

  ras_ctrl #(.XLEN(32)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    bit          is_push;
    logic [31:0] data;
    int          at_cyc;
  } ev_t;

  ev_t ev_q[$];
  int  exp_calls;
  int  exp_rets;
  int  exp_uf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter used to timestamp expected pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Rule-level classification: 0 none, 1 call, 2 return, 3 coroutine
  function automatic int model_class(input logic [31:0] ins);
    int  rd, rs;
    bit  lrd, lrs, jal, jalr;
    rd   = int'(ins[11:7]);
    rs   = int'(ins[19:15]);
    lrd  = (rd == 1) || (rd == 5);
    lrs  = (rs == 1) || (rs == 5);
    jal  = (ins[6:0] == 7'h6F);
    jalr = (ins[6:0] == 7'h67) && (ins[14:12] == 3'd0);
    if (jal) return lrd ? 1 : 0;
    if (!jalr) return 0;
    if (lrd && !lrs) return 1;
    if (lrd && lrs) return (rd == rs) ? 1 : 3;
    if (lrs) return 2;
    return 0;
  endfunction

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd1;
    if (k == 2) return 5'd5;
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 3);
    w[11:7]  = pick_reg();
    w[19:15] = pick_reg();
    if (k == 0) w[6:0] = 7'h6F;
    else if (k == 1) begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
    else if (k == 2) begin w[6:0] = 7'h67; w[14:12] = 3'($urandom_range(1, 7)); end
    else w[6:0] = 7'h13;
    return w;
  endfunction

  // Monitor: every pulse the DUT emits must match the head of the scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (bus.ras_push_o && bus.ras_pop_o)
      check(1'b0, "push_and_pop_same_cycle", 32'd1, 32'd0);
    else if (bus.ras_push_o || bus.ras_pop_o) begin
      if (ev_q.size() == 0) begin
        check(1'b0, "unexpected_pulse", {31'd0, bus.ras_push_o}, 32'd0);
      end else begin
        e = ev_q.pop_front();
        check(bus.ras_push_o == e.is_push, "pulse_kind", {31'd0, bus.ras_push_o}, {31'd0, e.is_push});
        check(cyc == e.at_cyc, "pulse_cycle", 32'(cyc), 32'(e.at_cyc));
        if (e.is_push)
          check(bus.ras_data_o == e.data, "push_data", bus.ras_data_o, e.data);
      end
    end
  end

  // Drive one instruction (optionally stalled first), predict its effects and check busy/pred
  task automatic do_txn(input logic [31:0] instr, input logic [31:0] pc, input bit empty,
                        input logic [31:0] top, input bit flush, input int stall_cycles);
    int          cls, nbusy;
    bit          exp_pv;
    logic [31:0] ra;
    ev_t         e;
    cls    = model_class(instr);
    ra     = pc + 32'd4;
    exp_pv = ((cls == 2) || (cls == 3)) && !empty && !flush;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_instr_i = instr;
    bus.fetch_pc_i    = pc;
    bus.ras_empty_i   = empty;
    bus.ras_top_i     = top;
    bus.flush_i       = flush;
    bus.stall_i       = (stall_cycles > 0);
    for (int s = 0; s < stall_cycles; s++) begin
      #2;
      check(bus.busy_o == 1'b0, "busy_during_stall", {31'd0, bus.busy_o}, 32'd0);
      @(posedge clk); #1;
    end
    bus.stall_i = 1'b0;
    #2;
    check(bus.pred_valid_o == exp_pv, "pred_valid", {31'd0, bus.pred_valid_o}, {31'd0, exp_pv});
    check(bus.pred_target_o == (exp_pv ? top : 32'd0), "pred_target", bus.pred_target_o, exp_pv ? top : 32'd0);
    nbusy = 0;
    if (!flush) begin
      if (cls == 1) begin
        e = '{1'b1, ra, cyc + 1}; ev_q.push_back(e); exp_calls++; nbusy = 1;
      end else if (cls == 2) begin
        if (empty) exp_uf++;
        else begin e = '{1'b0, 32'd0, cyc + 1}; ev_q.push_back(e); exp_rets++; nbusy = 1; end
      end else if (cls == 3) begin
        if (empty) begin
          exp_uf++;
          e = '{1'b1, ra, cyc + 1}; ev_q.push_back(e); exp_calls++; nbusy = 1;
        end else begin
          e = '{1'b0, 32'd0, cyc + 1}; ev_q.push_back(e);
          e = '{1'b1, ra, cyc + 2}; ev_q.push_back(e);
          exp_rets++; exp_calls++; nbusy = 2;
        end
      end
    end
    @(posedge clk); #1;
    bus.fetch_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    for (int b = 0; b < nbusy; b++) begin
      #2;
      check(bus.busy_o == 1'b1, "busy_high", {31'd0, bus.busy_o}, 32'd1);
      @(posedge clk); #1;
    end
    #2;
    check(bus.busy_o == 1'b0, "busy_low", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    ev_t e;
    n_checks = 0; n_pass = 0; cyc = 0;
    exp_calls = 0; exp_rets = 0; exp_uf = 0;
    rst_n = 1'b0;
    bus.fetch_valid_i = 1'b0; bus.fetch_pc_i = 32'd0; bus.fetch_instr_i = 32'd0;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.ras_top_i = 32'd0; bus.ras_empty_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(bus.ras_push_o == 1'b0, "reset_push", {31'd0, bus.ras_push_o}, 32'd0);
    check(bus.ras_pop_o == 1'b0, "reset_pop", {31'd0, bus.ras_pop_o}, 32'd0);
    check(bus.ras_data_o == 32'd0, "reset_data", bus.ras_data_o, 32'd0);
    check(bus.busy_o == 1'b0, "reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check(bus.pred_valid_o == 1'b0, "reset_pred", {31'd0, bus.pred_valid_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed scenarios
    do_txn(32'h0000_00EF, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 0); // JAL x1
    do_txn(32'h0000_8067, 32'h0000_0150, 1'b0, 32'h0000_0104, 1'b0, 0); // JALR x0,0(x1)
    do_txn(32'h0000_82E7, 32'h0000_0200, 1'b0, 32'h0000_0ABC, 1'b0, 0); // JALR x5,0(x1)
    do_txn(32'h0000_8067, 32'h0000_0300, 1'b1, 32'h0000_0000, 1'b0, 0); // return on empty
    do_txn(32'h0000_82E7, 32'h0000_0310, 1'b1, 32'h0000_0000, 1'b0, 0); // coroutine on empty
    do_txn(32'h0000_00EF, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 0); // wrap
    do_txn(32'h0000_00EF, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b1, 0); // flushed
    do_txn(32'h0000_00EF, 32'h0000_0500, 1'b0, 32'h0000_0000, 1'b0, 3); // stalled 3
    do_txn(32'h0000_00E7 | 32'h0000_8000, 32'h0000_0600, 1'b0, 32'h0000_1234, 1'b0, 0); // JALR x1,0(x1): push

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      do_txn(gen_instr(), {$urandom} & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0),
             $urandom, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    check(ev_q.size() == 0, "scoreboard_drained", 32'(ev_q.size()), 32'd0);
`ifdef RAS_CTRL_STATS_EN
    check(bus.stat_call_o == 32'(exp_calls), "stat_call", bus.stat_call_o, 32'(exp_calls));
    check(bus.stat_ret_o == 32'(exp_rets), "stat_ret", bus.stat_ret_o, 32'(exp_rets));
    check(bus.stat_underflow_o == 16'(exp_uf), "stat_underflow", {16'd0, bus.stat_underflow_o}, 32'(exp_uf));
`endif

    // reset while in COPOP: the pending push must never appear
    bus.fetch_valid_i = 1'b1; bus.fetch_instr_i = 32'h0000_82E7; bus.fetch_pc_i = 32'h0000_0700;
    bus.ras_empty_i = 1'b0; bus.ras_top_i = 32'h0000_0800;
    e = '{1'b0, 32'd0, cyc + 1}; ev_q.push_back(e);
    @(posedge clk); #1;
    bus.fetch_valid_i = 1'b0;
    check(bus.busy_o == 1'b1, "copop_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check(bus.ras_push_o == 1'b0, "abort_push", {31'd0, bus.ras_push_o}, 32'd0);
    check(bus.ras_pop_o == 1'b0, "abort_pop", {31'd0, bus.ras_pop_o}, 32'd0);
    check(bus.busy_o == 1'b0, "abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check(bus.ras_data_o == 32'd0, "abort_data", bus.ras_data_o, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(ev_q.size() == 0, "final_drained", 32'(ev_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
